// File: rtl/fetch_queue.sv
// Instruction-fetch front end: one outstanding imem read per PC value, results buffered in an
// in-order queue toward decode, wrong-path responses squashed on redirect.
module fetch_queue #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] pc_f,
  output logic        pc_hold,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW:0] DepthW = DEPTH[CntW:0];

  typedef enum logic [1:0] {StIdle, StWait, StWaitKill} state_e;

  state_e          state_q;
  logic [PtrW-1:0] head_q, tail_q;
  logic [CntW-1:0] count_q;
  logic [31:0]     req_pc_q;
  logic            init_q;

  logic [31:0] instr_mem [DEPTH];
  logic [31:0] pc_mem    [DEPTH];

  logic        out, pop, push, issue;
  logic [CntW:0] used;

  assign out      = state_q != StIdle;
  assign id_valid = count_q != '0;
  assign pop      = id_valid & id_ready & ~redirect;
  assign push     = imem_rvalid & (state_q == StWait);

  // Slots already committed: queued entries plus the in-flight fetch, minus the one leaving now.
  assign used = {1'b0, count_q} + {{CntW{1'b0}}, out} - {{CntW{1'b0}}, pop};

  // init_q keeps the request low for the first cycle after clr.
  assign imem_req  = ~clr & ~init_q & ~redirect & (~out | imem_rvalid) & (used < DepthW);
  assign issue     = imem_req & imem_gnt;
  assign pc_hold   = ~(issue | redirect);
  assign imem_addr = pc_f;

  assign id_instr = instr_mem[head_q];
  assign id_pc    = pc_mem[head_q];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      req_pc_q <= '0;
      init_q   <= 1'b1;
    end else begin
      init_q <= 1'b0;
      if (issue) req_pc_q <= pc_f;
      if (redirect) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        if (out) state_q <= imem_rvalid ? StIdle : StWaitKill;
      end else begin
        if (issue) begin
          state_q <= StWait;
        end else if (out && imem_rvalid) begin
          state_q <= StIdle;
        end
        if (push) tail_q <= tail_q + PtrW'(1);
        if (pop)  head_q <= head_q + PtrW'(1);
        if (push && !pop) begin
          count_q <= count_q + CntW'(1);
        end else if (pop && !push) begin
          count_q <= count_q - CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr && !redirect && push) begin
      instr_mem[tail_q] <= imem_rdata;
      pc_mem[tail_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: PC register and memory modelled as the environment, plus a
// queue-level reference model compared against the DUT every cycle.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;

  logic        clk;
  logic        clr;
  logic [31:0] pc_f;
  logic        pc_hold;
  logic        redirect;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        id_ready;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .clr        (clr),
    .pc_f       (pc_f),
    .pc_hold    (pc_hold),
    .redirect   (redirect),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_ready   (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'h3000) return 32'h2402000a;
    return (a << 8) | 32'h13;
  endfunction

  // Environment state: memory with one pending response, redirect target, response latency.
  logic [31:0] redir_tgt = 32'h0;
  int          lat = 1;
  logic        mpend = 1'b0;
  int          mdue = 0;
  logic [31:0] maddr = 32'h0;

  // One clock cycle: sample at the falling edge, then update PC register and memory after rise.
  task automatic step();
    logic        iss;
    logic [31:0] addr;
    logic        hold;
    @(negedge clk);
    iss  = imem_req & imem_gnt;
    addr = imem_addr;
    hold = pc_hold;
    @(posedge clk);
    #1;
    if (clr)           pc_f = 32'h3000;
    else if (redirect) pc_f = redir_tgt;
    else if (!hold)    pc_f = pc_f + 32'd4;
    if (iss) begin
      mpend = 1'b1;
      mdue  = lat;
      maddr = addr;
    end
    imem_rvalid = 1'b0;
    if (mpend) begin
      if (mdue <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = instr_of(maddr);
        mpend       = 1'b0;
      end else begin
        mdue--;
      end
    end
  endtask

  // Reference model: an ordered list of entries plus one in-flight fetch with a squash flag.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic        m_busy = 1'b0;
  logic        m_kill = 1'b0;
  logic        m_init = 1'b1;
  logic [31:0] m_pc = 32'h0;
  logic        model_on = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic e_valid, e_pop, e_req, e_hold;
    int   committed;
    ent_t e;
    if (model_on) begin
      e_valid   = mq.size() != 0;
      e_pop     = e_valid && id_ready && !redirect;
      committed = mq.size() + (m_busy ? 1 : 0) - (e_pop ? 1 : 0);
      e_req     = !clr && !m_init && !redirect && (!m_busy || imem_rvalid) && committed < DEPTH;
      e_hold    = !((e_req && imem_gnt) || redirect);
      chk("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
      chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      chk("pc_hold", {31'b0, pc_hold}, {31'b0, e_hold});
      if (e_valid) begin
        chk("id_instr", id_instr, mq[0].instr);
        chk("id_pc", id_pc, mq[0].pc);
      end
      if (e_req) chk("imem_addr", imem_addr, pc_f);
      if (clr) begin
        mq.delete();
        m_busy = 1'b0;
        m_kill = 1'b0;
        m_init = 1'b1;
      end else begin
        m_init = 1'b0;
        if (redirect) begin
          mq.delete();
          if (m_busy && !imem_rvalid) begin
            m_kill = 1'b1;
          end else begin
            m_busy = 1'b0;
            m_kill = 1'b0;
          end
        end else begin
          if (e_pop) void'(mq.pop_front());
          if (m_busy && imem_rvalid) begin
            if (!m_kill) begin
              e.instr = imem_rdata;
              e.pc    = m_pc;
              mq.push_back(e);
            end
            m_busy = 1'b0;
            m_kill = 1'b0;
          end
          if (e_req && imem_gnt) begin
            m_busy = 1'b1;
            m_kill = 1'b0;
            m_pc   = pc_f;
          end
        end
      end
    end
  end

  initial begin
    clr = 1'b1; pc_f = 32'h3000; redirect = 1'b0; imem_gnt = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0; id_ready = 1'b0;

    // Reset, single fetch, then a grant held off for three cycles.
    step(); model_on = 1'b1; #1;
    chk("t1 rst valid", {31'b0, id_valid}, 32'd0);
    chk("t1 rst req", {31'b0, imem_req}, 32'd0);
    chk("t1 rst hold", {31'b0, pc_hold}, 32'd1);
    step(); clr = 1'b0; imem_gnt = 1'b1; #1;
    chk("t1 post-clr req", {31'b0, imem_req}, 32'd0);
    chk("t1 post-clr hold", {31'b0, pc_hold}, 32'd1);
    step(); #1;
    chk("t1 issue req", {31'b0, imem_req}, 32'd1);
    chk("t1 issue hold", {31'b0, pc_hold}, 32'd0);
    chk("t1 issue addr", imem_addr, 32'h3000);
    step(); imem_gnt = 1'b0; #1;
    chk("t1 resp valid", {31'b0, id_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        step(); #1;
      end
      chk("t5 req", {31'b0, imem_req}, 32'd1);
      chk("t5 addr", imem_addr, 32'h3004);
      chk("t5 hold", {31'b0, pc_hold}, 32'd1);
      if (k == 1) begin
        chk("t1 valid", {31'b0, id_valid}, 32'd1);
        chk("t1 instr", id_instr, 32'h2402000a);
        chk("t1 pc", id_pc, 32'h3000);
      end
    end
    step(); imem_gnt = 1'b1; id_ready = 1'b1; #1;
    chk("t5 grant hold", {31'b0, pc_hold}, 32'd0);
    chk("t5 grant pc", id_pc, 32'h3000);
    step(); imem_gnt = 1'b0; #1;
    chk("t5 next addr", imem_addr, 32'h3008);

    // Streaming with a 1-cycle memory.
    clr = 1'b1; id_ready = 1'b0;
    step(); clr = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      chk("t2 valid", {31'b0, id_valid}, 32'd1);
      chk("t2 pc", id_pc, 32'h3000 + 32'(4 * k));
    end

    // Back-pressure: decode stalls after the first fetch.
    clr = 1'b1; id_ready = 1'b0; imem_gnt = 1'b0;
    step(); clr = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
    step(); id_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      step(); #1;
      chk("t3 full req", {31'b0, imem_req}, 32'd0);
      chk("t3 full hold", {31'b0, pc_hold}, 32'd1);
      chk("t3 full pc", id_pc, 32'h3000);
    end
    step(); id_ready = 1'b1; #1;
    chk("t3 resume hold", {31'b0, pc_hold}, 32'd0);
    chk("t3 resume pc", id_pc, 32'h3000);
    for (int k = 1; k < 4; k++) begin
      step(); #1;
      chk("t3 order pc", id_pc, 32'h3000 + 32'(4 * k));
    end

    // Redirect while the fetch of 0x3008 is outstanding.
    clr = 1'b1; id_ready = 1'b0; imem_gnt = 1'b0;
    step(); clr = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1; lat = 1;
    step(); step();
    step(); lat = 3; #1;
    chk("t4 addr", imem_addr, 32'h3008);
    step(); redirect = 1'b1; redir_tgt = 32'h3100; #1;
    chk("t4 redir req", {31'b0, imem_req}, 32'd0);
    chk("t4 redir hold", {31'b0, pc_hold}, 32'd0);
    step(); redirect = 1'b0; lat = 1; #1;
    chk("t4 flushed", {31'b0, id_valid}, 32'd0);
    chk("t4 kill req", {31'b0, imem_req}, 32'd0);
    step(); #1;
    chk("t4 stale rvalid", {31'b0, imem_rvalid}, 32'd1);
    chk("t4 new addr", imem_addr, 32'h3100);
    chk("t4 new req", {31'b0, imem_req}, 32'd1);
    chk("t4 stale dropped", {31'b0, id_valid}, 32'd0);
    step(); step(); #1;
    chk("t4 target valid", {31'b0, id_valid}, 32'd1);
    chk("t4 target pc", id_pc, 32'h3100);

    // Reset with a queued entry and a fetch in flight; its response lands after clr.
    clr = 1'b1; id_ready = 1'b0; imem_gnt = 1'b0;
    step(); clr = 1'b0; imem_gnt = 1'b1; lat = 1;
    step();
    step(); lat = 2;
    step(); clr = 1'b1; #1;
    chk("t6 pre valid", {31'b0, id_valid}, 32'd1);
    chk("t6 clr req", {31'b0, imem_req}, 32'd0);
    step(); clr = 1'b0; imem_gnt = 1'b0; #1;
    chk("t6 stale rvalid", {31'b0, imem_rvalid}, 32'd1);
    chk("t6 valid", {31'b0, id_valid}, 32'd0);
    chk("t6 req", {31'b0, imem_req}, 32'd0);
    step(); #1;
    chk("t6 not queued", {31'b0, id_valid}, 32'd0);
    chk("t6 restart addr", imem_addr, 32'h3000);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
